// File: rtl/pmem_loader_pkg.sv
// rtl/pmem_loader_pkg.sv - shared state encoding and helpers for the program-memory loader
package pmem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [1:0] LANE_LAST = 2'd3;

    // States in which a frame is being received and bytes are accepted.
    function automatic logic is_busy(state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/pmem_loader_word_packer.sv
// rtl/pmem_loader_word_packer.sv - packs accepted bytes little-endian into 32-bit words
module word_packer
    import pmem_loader_pkg::*;
(
    input  logic        sysclk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  lane
);

    logic [23:0] sr;

    // The first byte of a word shifts down to bits [7:0] by the time the fourth arrives.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            lane       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= '0;
            end else if (byte_valid) begin
                sr   <= {byte_data, sr[23:8]};
                lane <= lane + 2'd1;
                if (lane == LANE_LAST) begin
                    word       <= {byte_data, sr};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pmem_loader.sv
// rtl/pmem_loader.sv - framed byte-stream loader for program memory; holds CPU in reset until image verified
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr,
    output logic [31:0]                pmem_wr_data,
    output logic [3:0]                 pmem_byte_w_en,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH+1)'(1) << PMEM_ADDR_WIDTH;

    state_t                 state;
    state_t                 nxt;
    logic [7:0]             len_lo;
    logic [7:0]             xor_acc;
    logic [LEN_WIDTH-1:0]   len;
    logic [LEN_WIDTH-1:0]   len_in;
    logic [LEN_WIDTH-1:0]   word_cnt;
    logic                   accept;
    logic                   data_accept;
    logic                   word_done;
    logic                   start_take;
    logic [1:0]             lane;
    logic                   word_valid;
    logic [31:0]            word;

    assign accept      = rx_valid && rx_ready;
    assign data_accept = accept && (state == ST_DATA);
    assign word_done   = data_accept && (lane == LANE_LAST);
    assign start_take  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign len_in      = LEN_WIDTH'({rx_data, len_lo});

    word_packer u_packer (
        .sysclk     (sysclk),
        .rst        (rst),
        .clear      (start_take),
        .byte_data  (rx_data),
        .byte_valid (data_accept),
        .word       (word),
        .word_valid (word_valid),
        .lane       (lane)
    );

    assign pmem_wr_data   = word;
    assign pmem_byte_w_en = {4{word_valid}};

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) nxt = ST_LEN_LO;
            ST_LEN_LO: if (accept) nxt = ST_LEN_HI;
            ST_LEN_HI: if (accept) begin
                if (len_in == '0)                  nxt = ST_CHECK;
                else if ({1'b0, len_in} > MAX_WORDS) nxt = ST_ERROR;
                else                               nxt = ST_DATA;
            end
            ST_DATA: if (word_done && (word_cnt == len - LEN_WIDTH'(1))) nxt = ST_CHECK;
            ST_CHECK: if (accept) nxt = (rx_data == xor_acc) ? ST_DONE : ST_ERROR;
            default: nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state change.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_rst      <= 1'b1;
            len_lo       <= '0;
            len          <= '0;
            word_cnt     <= '0;
            xor_acc      <= '0;
            pmem_wr_addr <= '0;
        end else begin
            state    <= nxt;
            rx_ready <= is_busy(nxt);
            busy     <= is_busy(nxt);
            done     <= (nxt == ST_DONE);
            error    <= (nxt == ST_ERROR);
            cpu_rst  <= (nxt != ST_DONE);
            if (start_take) begin
                word_cnt     <= '0;
                xor_acc      <= '0;
                pmem_wr_addr <= '0;
            end
            if (accept && (state == ST_LEN_LO)) len_lo <= rx_data;
            if (accept && (state == ST_LEN_HI)) len <= len_in;
            if (data_accept) xor_acc <= xor_acc ^ rx_data;
            if (word_done) begin
                pmem_wr_addr <= PMEM_ADDR_WIDTH'(word_cnt);
                word_cnt     <= word_cnt + LEN_WIDTH'(1);
            end
        end
    end

endmodule
